// File: rtl/array_drain.sv
// Drain side of the systolic array: de-skews the staggered down_out stream into a
// ROW_NUMBER x COLUMN_NUMBER result buffer, then streams it out one row per handshake.
module array_drain #(
    parameter int ROW_NUMBER    = 4,
    parameter int COLUMN_NUMBER = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [DATA_WIDTH-1:0]                 down_out [0:COLUMN_NUMBER-1],
    output logic                                  busy,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [COLUMN_NUMBER*DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(ROW_NUMBER)-1:0]         out_row,
    output logic                                  out_last,
    output logic                                  done
);

    localparam int LAST_T = ROW_NUMBER + COLUMN_NUMBER - 2;
    localparam int CW     = $clog2(ROW_NUMBER + COLUMN_NUMBER);
    localparam int RW     = $clog2(ROW_NUMBER);
    localparam int ROW_W  = COLUMN_NUMBER * DATA_WIDTH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_OUTPUT  = 2'd2;

    logic [1:0]                         state_reg;
    logic [CW-1:0]                      cnt_reg;
    logic [RW-1:0]                      row_ptr_reg;
    logic [RW-1:0]                      row_ptr_next;
    logic [ROW_NUMBER*ROW_W-1:0]        buffer_flat;
    logic                               capture_en;

    assign capture_en   = (state_reg == S_CAPTURE);
    assign row_ptr_next = row_ptr_reg + 1'b1;
    assign busy         = (state_reg != S_IDLE);
    assign out_row      = row_ptr_reg;

    // Element (r,c) arrives on lane c exactly at capture step c + (ROW_NUMBER-1-r),
    // so every cell has a fixed write slot and out-of-window lane data is never stored.
    generate
        for (genvar gi = 0; gi < ROW_NUMBER; gi++) begin : g_row
            for (genvar gj = 0; gj < COLUMN_NUMBER; gj++) begin : g_col
                logic [DATA_WIDTH-1:0] cell_reg;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        cell_reg <= '0;
                    end else if (capture_en && cnt_reg == CW'(gj + ROW_NUMBER - 1 - gi)) begin
                        cell_reg <= down_out[gj];
                    end
                end

                assign buffer_flat[gi*ROW_W + gj*DATA_WIDTH +: DATA_WIDTH] = cell_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            row_ptr_reg <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_CAPTURE;
                        cnt_reg   <= '0;
                    end
                end
                S_CAPTURE: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(LAST_T)) begin
                        state_reg   <= S_OUTPUT;
                        row_ptr_reg <= '0;
                    end
                end
                S_OUTPUT: begin
                    // First OUTPUT cycle only loads row 0 from the freshly written buffer.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= buffer_flat[int'(row_ptr_reg)*ROW_W +: ROW_W];
                        out_last  <= (int'(row_ptr_reg) == ROW_NUMBER - 1);
                    end else if (out_ready) begin
                        if (out_last) begin
                            state_reg <= S_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            row_ptr_reg <= row_ptr_next;
                            out_data    <= buffer_flat[int'(row_ptr_next)*ROW_W +: ROW_W];
                            out_last    <= (int'(row_ptr_next) == ROW_NUMBER - 1);
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
